// File: rtl/conf_frame_ctrl_pkg.sv
// Shared definitions for the configuration frame controller: parameter
// indices, frame constants, FSM state encodings and width helper.
package conf_pkg;

   function automatic int width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int CONF_PAR_MAX     = 255;
   localparam int PAR_W            = width(CONF_PAR_MAX);
   localparam int NUM_PAR          = 5;
   localparam int CONF_DEF         = 0;
   localparam int BYTE_TIMEOUT_DEF = 1040;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // 0 ref_gen, 1 phase_shift, 2 ocd_lvl, 3 inter_freq, 4 inter_duty
   typedef enum logic [2:0] {
      CONF_PAR_0 = 3'd0,
      CONF_PAR_1 = 3'd1,
      CONF_PAR_2 = 3'd2,
      CONF_PAR_3 = 3'd3,
      CONF_PAR_4 = 3'd4
   } conf_par_e;

   typedef logic [NUM_PAR-1:0][PAR_W-1:0] conf_arr_t;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] CHECK   = 2'd2;
   localparam logic [1:0] PENDING = 2'd3;

endpackage

// File: rtl/conf_frame_ctrl_tmo.sv
// Loadable down-counter timeout: clr reloads, en counts, exp flags the
// cycle in which an enabled count passes zero.
module frame_tmo #(
   parameter int LOAD = 1039,
   parameter int W    = $clog2(LOAD + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic exp
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= W'(LOAD);
      else if (en)
         cnt <= (cnt == '0) ? W'(LOAD) : cnt - W'(1);
   end

   assign exp = en && !clr && (cnt == '0);

endmodule

// File: rtl/conf_frame_ctrl.sv
// Frame parser for UART-delivered configuration: SYNC, 5 params, XOR check;
// the new set is committed atomically only while the core is idle.
module conf_frame_ctrl
   import conf_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int         BYTE_TIMEOUT = BYTE_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   input  logic            core_idle,
   output conf_arr_t       conf,
   output logic            conf_upd,
   output logic            busy,
   output logic            err_sync,
   output logic            err_crc,
   output logic            err_tmo,
   output logic            err_busy
);

   localparam logic [2:0] IDX_LAST = 3'(NUM_PAR - 1);

   logic [1:0] state, state_nxt;
   logic [2:0] idx;
   logic [7:0] acc;
   conf_arr_t  shadow;
   logic       in_frame, tmo_exp;

   assign in_frame = (state == PAYLOAD) || (state == CHECK);

   // A byte arriving in the expiry cycle reloads the counter, so it wins.
   frame_tmo #(.LOAD(BYTE_TIMEOUT - 1)) u_tmo (
      .clk (clk),
      .rst (rst),
      .clr (!in_frame || rx_valid),
      .en  (in_frame && !rx_valid),
      .exp (tmo_exp)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_nxt = PAYLOAD;
         PAYLOAD: begin
            if (rx_valid && idx == IDX_LAST) state_nxt = CHECK;
            else if (tmo_exp)                state_nxt = IDLE;
         end
         CHECK: begin
            if (rx_valid)     state_nxt = (rx_data == acc) ? PENDING : IDLE;
            else if (tmo_exp) state_nxt = IDLE;
         end
         PENDING: if (core_idle) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         acc      <= '0;
         shadow   <= '0;
         conf     <= {NUM_PAR{PAR_W'(CONF_DEF)}};
         conf_upd <= 1'b0;
         busy     <= 1'b0;
         err_sync <= 1'b0;
         err_crc  <= 1'b0;
         err_tmo  <= 1'b0;
         err_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != IDLE);
         err_sync <= (state == IDLE) && rx_valid && (rx_data != SYNC_BYTE);
         err_crc  <= (state == CHECK) && rx_valid && (rx_data != acc);
         err_tmo  <= tmo_exp;
         err_busy <= (state == PENDING) && rx_valid;
         conf_upd <= (state == PENDING) && core_idle;

         if (state == IDLE && rx_valid && rx_data == SYNC_BYTE) begin
            idx <= '0;
            acc <= '0;
         end
         // Sync-valued payload bytes are plain data; no resync mid-frame.
         if (state == PAYLOAD && rx_valid) begin
            shadow[idx] <= PAR_W'(rx_data);
            acc         <= acc ^ rx_data;
            if (idx != IDX_LAST) idx <= idx + 3'd1;
         end
         if (state == PENDING && core_idle)
            conf <= shadow;
      end
   end

endmodule

// File: tb/tb_conf_frame_ctrl.sv
// Scoreboard bench: expected output pulses are queued as bytes are driven
// and matched (kind, cycle, conf) as the DUT raises them.
module tb_conf_frame_ctrl;
   import conf_pkg::*;

   localparam int BT = 1040;
   localparam int K_UPD = 1, K_SYNC = 2, K_CRC = 3, K_TMO = 4, K_BUSY = 5;

   typedef struct {
      int          kind;
      int          cyc;
      logic [39:0] cval;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       core_idle = 1'b1;
   conf_arr_t  conf;
   logic       conf_upd, busy, err_sync, err_crc, err_tmo, err_busy;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   ev_t sbq[$];

   conf_frame_ctrl dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .core_idle(core_idle), .conf(conf), .conf_upd(conf_upd), .busy(busy),
      .err_sync(err_sync), .err_crc(err_crc), .err_tmo(err_tmo),
      .err_busy(err_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int at, input logic [39:0] cv);
      ev_t e;
      e.kind = kind; e.cyc = at; e.cval = cv;
      sbq.push_back(e);
   endtask

   // Strobe one byte for one cycle; p is the cycle in which it is driven.
   task automatic send(input logic [7:0] b, output int p);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = b; p = cyc;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse seen must match the head of the scoreboard.
   always @(negedge clk) begin
      logic [4:0] pl;
      ev_t e;
      pl = {err_busy, err_tmo, err_crc, err_sync, conf_upd};
      for (int k = 1; k <= 5; k++) begin
         if (pl[k-1]) begin
            if (sbq.size() == 0) begin
               chk("unexpected_pulse", 64'(k), 64'(0));
            end else begin
               e = sbq.pop_front();
               chk("pulse_kind", 64'(k), 64'(e.kind));
               chk("pulse_cyc", 64'(cyc), 64'(e.cyc));
               if (k == K_UPD) chk("conf_on_upd", 64'(conf), 64'(e.cval));
            end
         end
      end
   end

   initial begin
      int p;
      logic [39:0] good, noise;
      good  = {8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
      noise = {8'h04, 8'h03, 8'h02, 8'h01, 8'hA5};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_conf", 64'(conf), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));

      // Good frame, core idle: commit two cycles after CHK strobe.
      send(8'hA5, p); send(8'h10, p); send(8'h20, p); send(8'h30, p);
      send(8'h40, p); send(8'h50, p);
      @(negedge clk);
      chk("busy_in_frame", 64'(busy), 64'(1));
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = 8'h10; p = cyc;
      push(K_UPD, p + 2, good);
      @(posedge clk); #1 rx_valid = 1'b0;
      idle_cycles(4);
      @(negedge clk);
      chk("good_conf", 64'(conf), 64'(good));
      chk("good_busy", 64'(busy), 64'(0));

      // Bad checksum.
      send(8'hA5, p); send(8'h11, p); send(8'h22, p); send(8'h33, p);
      send(8'h44, p); send(8'h55, p);
      send(8'h12, p); push(K_CRC, p + 1, '0);
      idle_cycles(3);
      @(negedge clk);
      chk("crc_conf", 64'(conf), 64'(good));
      chk("crc_busy", 64'(busy), 64'(0));

      // Inter-byte timeout, then a good frame commits normally.
      send(8'hA5, p); send(8'h10, p); send(8'h20, p);
      push(K_TMO, p + 1 + BT, '0);
      idle_cycles(BT + 10);
      @(negedge clk);
      chk("tmo_busy", 64'(busy), 64'(0));
      send(8'hA5, p); send(8'h01, p); send(8'h02, p); send(8'h03, p);
      send(8'h04, p); send(8'h05, p);
      send(8'h01, p); push(K_UPD, p + 2, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
      idle_cycles(4);

      // Idle gating: frame held in PENDING; a sync byte there is refused.
      core_idle = 1'b0;
      send(8'hA5, p); send(8'h10, p); send(8'h20, p); send(8'h30, p);
      send(8'h40, p); send(8'h50, p); send(8'h10, p);
      idle_cycles(200);
      send(8'hA5, p); push(K_BUSY, p + 1, '0);
      idle_cycles(2);
      @(negedge clk);
      chk("pend_busy", 64'(busy), 64'(1));
      chk("pend_conf", 64'(conf), 64'({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}));
      @(posedge clk); #1;
      core_idle = 1'b1; push(K_UPD, cyc + 1, good);
      idle_cycles(3);
      @(negedge clk);
      chk("pend_commit", 64'(conf), 64'(good));

      // Noise bytes, then a frame whose first payload byte equals SYNC.
      send(8'h00, p); push(K_SYNC, p + 1, '0);
      send(8'hA4, p); push(K_SYNC, p + 1, '0);
      send(8'hA5, p); send(8'hA5, p); send(8'h01, p); send(8'h02, p);
      send(8'h03, p); send(8'h04, p);
      send(8'hA1, p); push(K_UPD, p + 2, noise);
      idle_cycles(4);
      @(negedge clk);
      chk("noise_conf", 64'(conf), 64'(noise));

      // Reset mid-frame: frame dropped, conf to default, no pulses.
      send(8'hA5, p); send(8'h10, p); send(8'h20, p);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_conf", 64'(conf), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      send(8'h30, p); push(K_SYNC, p + 1, '0);
      send(8'h40, p); push(K_SYNC, p + 1, '0);
      send(8'h50, p); push(K_SYNC, p + 1, '0);
      send(8'h11, p); push(K_SYNC, p + 1, '0);
      idle_cycles(5);
      @(negedge clk);
      chk("rst_tail_conf", 64'(conf), 64'(0));
      chk("sb_drained", 64'(sbq.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
